instr_fetch: RTL

Fetch stage of the uPOWER datapath. It holds the PC and runs a req/ack handshake with instruction memory. It latches each returned 32-bit word into an instruction register and splits it into the fields the control unit consumes (opcode, xox, xoxo, xods) and the fields the register file and ALU consume. Output uses a valid/ready handshake, and branch redirects arrive from execute.

---
 rtl/upower_pkg.sv | 23 ++
 rtl/instr_fields.sv | 27 ++
 rtl/instr_fetch.sv | 102 ++++++++++
 3 files changed

// File: rtl/upower_pkg.sv
// upower_pkg: shared fetch-state encoding, instruction width and field bit positions
package upower_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, SQUASH} fetch_state_t;
    localparam int INSTR_W   = 32;
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int XOX_HI    = 10;
    localparam int XOX_LO    = 1;
    localparam int XOXO_HI   = 9;
    localparam int XOXO_LO   = 1;
    localparam int XODS_HI   = 1;
    localparam int XODS_LO   = 0;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RA_HI     = 20;
    localparam int RA_LO     = 16;
    localparam int RB_HI     = 15;
    localparam int RB_LO     = 11;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int AA_BIT    = 1;
    localparam int LK_BIT    = 0;
endpackage

// File: rtl/instr_fields.sv
// instr_fields: pure wiring that splits a uPOWER instruction word into control and operand fields
module instr_fields
    import upower_pkg::*;
(
    input  logic [INSTR_W-1:0]           i_ir,
    output logic [OPCODE_HI-OPCODE_LO:0] o_opcode,
    output logic [XOX_HI-XOX_LO:0]       o_xox,
    output logic [XOXO_HI-XOXO_LO:0]     o_xoxo,
    output logic [XODS_HI-XODS_LO:0]     o_xods,
    output logic [RS_HI-RS_LO:0]         o_rs,
    output logic [RA_HI-RA_LO:0]         o_ra,
    output logic [RB_HI-RB_LO:0]         o_rb,
    output logic [IMM_HI-IMM_LO:0]       o_imm,
    output logic                         o_aa,
    output logic                         o_lk
);
    assign o_opcode = i_ir[OPCODE_HI:OPCODE_LO];
    assign o_xox    = i_ir[XOX_HI:XOX_LO];
    assign o_xoxo   = i_ir[XOXO_HI:XOXO_LO];
    assign o_xods   = i_ir[XODS_HI:XODS_LO];
    assign o_rs     = i_ir[RS_HI:RS_LO];
    assign o_ra     = i_ir[RA_HI:RA_LO];
    assign o_rb     = i_ir[RB_HI:RB_LO];
    assign o_imm    = i_ir[IMM_HI:IMM_LO];
    assign o_aa     = i_ir[AA_BIT];
    assign o_lk     = i_ir[LK_BIT];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, imem req/ack handshake and instruction register with valid/ready output.
// Redirects always win; an outstanding memory request is completed and discarded, never dropped.
module instr_fetch
    import upower_pkg::*;
#(
    parameter int            AW       = 64,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [AW-1:0]      redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AW-1:0]      out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [5:0]         opcode,
    output logic [9:0]         xox,
    output logic [8:0]         xoxo,
    output logic [1:0]         xods,
    output logic [4:0]         rs,
    output logic [4:0]         ra,
    output logic [4:0]         rb,
    output logic [15:0]        imm,
    output logic               aa,
    output logic               lk
);
    fetch_state_t       r_state;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      r_pend;
    logic [AW-1:0]      r_out_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [AW-1:0]      w_tgt;

    assign w_tgt = redirect_target & ~AW'(3);
    // pc is not advanced while a squashed request is in flight, so it is always the live address
    assign imem_addr = r_pc;
    assign imem_req  = (r_state == FETCH) || (r_state == SQUASH);
    assign out_valid = r_state == HOLD;
    assign out_pc    = r_out_pc;
    assign out_instr = r_ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_pend   <= RESET_PC;
            r_out_pc <= '0;
            r_ir     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect_valid) r_pc <= w_tgt;
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (redirect_valid && imem_ack) begin
                        r_pc <= w_tgt;
                    end else if (redirect_valid) begin
                        r_pend  <= w_tgt;
                        r_state <= SQUASH;
                    end else if (imem_ack) begin
                        r_ir     <= imem_rdata;
                        r_out_pc <= r_pc;
                        r_pc     <= r_pc + AW'(4);
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) r_pc <= w_tgt;
                    if (redirect_valid || out_ready) r_state <= FETCH;
                end
                default: begin
                    if (imem_ack) begin
                        r_pc    <= redirect_valid ? w_tgt : r_pend;
                        r_state <= FETCH;
                    end else if (redirect_valid) begin
                        r_pend <= w_tgt;
                    end
                end
            endcase
        end
    end

    instr_fields u_fields (
        .i_ir     (r_ir),
        .o_opcode (opcode),
        .o_xox    (xox),
        .o_xoxo   (xoxo),
        .o_xods   (xods),
        .o_rs     (rs),
        .o_ra     (ra),
        .o_rb     (rb),
        .o_imm    (imm),
        .o_aa     (aa),
        .o_lk     (lk)
    );
endmodule
